// File: rtl/packer_pkg.sv
// Shared types and default geometry for the UART word packer.
// byte_t / word_t describe one UART byte and one packed output word for the
// default build. slot_idx_t addresses an accumulator slot. fill_t holds a
// fill count that can also represent a completely full accumulator.
package packer_pkg;

  localparam int IN_WIDTH       = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = IN_WIDTH * BYTES_PER_WORD;
  localparam int SLOT_W         = $clog2(BYTES_PER_WORD);
  localparam int FILL_W         = $clog2(BYTES_PER_WORD + 1);

  typedef logic [IN_WIDTH-1:0] byte_t;
  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [SLOT_W-1:0]   slot_idx_t;
  typedef logic [FILL_W-1:0]   fill_t;

endpackage

// File: rtl/uart_word_packer_if.sv
// Handshake bundle between the UART receiver, the packer and the delay-line
// consumer. The master side drives bytes, flush requests and out_ready.
// The slave side is the packer itself.
interface uart_word_packer_if #(
  parameter int in_width       = packer_pkg::IN_WIDTH,
  parameter int bytes_per_word = packer_pkg::BYTES_PER_WORD
);

  logic [in_width-1:0]                 in_data;
  logic                                in_valid;
  logic                                in_ready;
  logic                                flush;
  logic [in_width*bytes_per_word-1:0]  out_data;
  logic                                out_valid;
  logic                                out_ready;
  logic [$clog2(bytes_per_word+1)-1:0] fill_level;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, fill_level
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, fill_level
  );

endinterface

// File: rtl/packer_hold_reg.sv
// One-word output buffer for the packer. A load always wins over a drain,
// so a word can replace the one leaving in the same cycle without a bubble.
// out_free_o tells the parent that a load this cycle is safe.
module packer_hold_reg
  import packer_pkg::*;
#(
  parameter int word_w = WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [word_w-1:0] word_i,
  input  logic              out_ready_i,
  output logic [word_w-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              out_free_o
);

  logic [word_w-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // The register is free when it is empty or its word leaves this cycle.
  assign out_free_o  = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  // Load takes priority; otherwise a completed drain empties the buffer.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = word_i;
      valid_d = 1'b1;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Word and valid flag registers, cleared while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART bytes into wide words for the training datapath.
// Bytes fill accumulator slots in arrival order. A full word, or a flushed
// partial word padded with zeros, moves into packer_hold_reg while the next
// word starts filling. reset is asynchronous and active-low.
// Build option: define PACKER_MSB_FIRST_EN to place the first byte of a word
// in the top slot. The default is little-endian, with the first byte in the
// low slot.
module uart_word_packer
  import packer_pkg::*;
#(
  parameter int in_width       = IN_WIDTH,
  parameter int bytes_per_word = BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  uart_word_packer_if.slave bus
);

  localparam int WordW = in_width * bytes_per_word;
  localparam int FillW = $clog2(bytes_per_word + 1);
  localparam logic [FillW-1:0] LastFill = FillW'(bytes_per_word - 1);

  logic [in_width-1:0] acc_q  [bytes_per_word];
  logic [in_width-1:0] acc_d  [bytes_per_word];
  logic [in_width-1:0] merged [bytes_per_word];
  logic [FillW-1:0]    fillLevel_q, fillLevel_d, fillAfter;
  logic                flushPending_q, flushPending_d;
  logic                outValid, outFree;
  logic                inReady, accept, lastSlot, wordDone, transfer;
  logic [WordW-1:0]    packedWord;

  // Stall only when a transfer is needed and the hold register cannot free.
  // A pending flush needs a transfer, and so does a byte arriving in the last
  // slot.
  assign lastSlot = (fillLevel_q == LastFill);
  assign inReady  = !((lastSlot || flushPending_q) && outValid && !bus.out_ready);
  assign accept   = bus.in_valid && inReady;
  assign fillAfter = fillLevel_q + FillW'(accept);

  // A word leaves either because the last slot filled or because a pending
  // flush found the hold register free. Either way the accumulator restarts.
  assign wordDone = accept && lastSlot;
  assign transfer = wordDone || (flushPending_q && outFree);

  assign bus.in_ready   = inReady;
  assign bus.out_valid  = outValid;
  assign bus.fill_level = fillLevel_q;

  // Accumulator view that includes the byte accepted this cycle. A flush that
  // executes now therefore carries that byte too.
  always_comb begin
    for (int i = 0; i < bytes_per_word; i++) begin
      merged[i] = acc_q[i];
      if (accept && (fillLevel_q == FillW'(i))) begin
        merged[i] = bus.in_data;
      end
    end
  end

  // Place slots into the outgoing word. Cleared slots supply the zero padding.
  always_comb begin
    packedWord = '0;
    for (int i = 0; i < bytes_per_word; i++) begin
`ifdef PACKER_MSB_FIRST_EN
      packedWord[(bytes_per_word-1-i)*in_width +: in_width] = merged[i];
`else
      packedWord[i*in_width +: in_width] = merged[i];
`endif
    end
  end

  // Next accumulator, fill level and flush flag. A flush request is
  // remembered only if bytes remain after this cycle. That rule drops a
  // flush that coincides with a full-word transfer, or one that arrives with
  // nothing buffered.
  always_comb begin
    fillLevel_d    = fillAfter;
    flushPending_d = flushPending_q || (bus.flush && (fillAfter != '0));
    for (int i = 0; i < bytes_per_word; i++) begin
      acc_d[i] = merged[i];
    end
    if (transfer) begin
      fillLevel_d    = '0;
      flushPending_d = 1'b0;
      for (int i = 0; i < bytes_per_word; i++) begin
        acc_d[i] = '0;
      end
    end
  end

  // Accumulator, slot counter and flush flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fillLevel_q    <= '0;
      flushPending_q <= 1'b0;
      for (int i = 0; i < bytes_per_word; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      fillLevel_q    <= fillLevel_d;
      flushPending_q <= flushPending_d;
      for (int i = 0; i < bytes_per_word; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  packer_hold_reg #(
    .word_w (WordW)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .load_i      (transfer),
    .word_i      (packedWord),
    .out_ready_i (bus.out_ready),
    .out_data_o  (bus.out_data),
    .out_valid_o (outValid),
    .out_free_o  (outFree)
  );

endmodule

// File: tb/tb_uart_word_packer.sv
// Bench for uart_word_packer with bytes_per_word = 4.
// A transaction-level model predicts the byte queue, the held word and the
// flush request. Directed scenarios run first, then a randomized run.
module tb_uart_word_packer;
  import packer_pkg::*;

  localparam int BPW = BYTES_PER_WORD;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_word_packer_if #(.in_width(IN_WIDTH), .bytes_per_word(BPW)) bus ();

  uart_word_packer #(
    .in_width       (IN_WIDTH),
    .bytes_per_word (BPW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state: bytes waiting, the held word and the flush request.
  byte_t mBytes[$];
  word_t mWord;
  bit    mValid;
  bit    mPend;
  word_t expWords[$];
  word_t gotWords[$];

  // Last DUT values seen during a stimulus cycle.
  logic        lastReady;
  logic        lastAccept;
  logic [31:0] lastFill;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic word_t packModel(input byte_t q[$]);
    word_t w;
    w = '0;
    for (int i = 0; i < q.size(); i++) begin
`ifdef PACKER_MSB_FIRST_EN
      w = w | (word_t'(q[i]) << (IN_WIDTH * (BPW - 1 - i)));
`else
      w = w | (word_t'(q[i]) << (IN_WIDTH * i));
`endif
    end
    return w;
  endfunction

  function automatic word_t expect4(input byte_t b0, input byte_t b1,
                                    input byte_t b2, input byte_t b3);
`ifdef PACKER_MSB_FIRST_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  // One clock cycle: drive at the falling edge, check just after it, then
  // advance the model for the coming rising edge.
  task automatic applyStimulus(input bit v, input byte_t d, input bit f,
                               input bit r, output bit accepted);
    bit expReady;
    bit outFree;
    bit full;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.flush     = f;
    bus.out_ready = r;
    #1;
    expReady = !(((mBytes.size() == BPW - 1) || mPend) && mValid && !r);
    checkOutput("in_ready", bus.in_ready, expReady);
    checkOutput("out_valid", bus.out_valid, mValid);
    if (mValid) checkOutput("out_data", bus.out_data, mWord);
    checkOutput("fill_level", bus.fill_level, mBytes.size());
    lastReady  = bus.in_ready;
    lastAccept = bus.in_valid && bus.in_ready;
    lastFill   = 32'(bus.fill_level);
    if (bus.out_valid && r) gotWords.push_back(bus.out_data);

    accepted = v && expReady;
    outFree  = !mValid || r;
    if (mValid && r) expWords.push_back(mWord);
    if (accepted) mBytes.push_back(d);
    full = accepted && (mBytes.size() == BPW);
    if (full || (mPend && outFree)) begin
      mWord  = packModel(mBytes);
      mValid = 1'b1;
      mBytes.delete();
      mPend  = 1'b0;
    end else begin
      if (mValid && r) mValid = 1'b0;
      if (f && mBytes.size() > 0) mPend = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  // Offer a byte until accepted, with a bounded number of attempts.
  task automatic offerByte(input byte_t d, input bit f, input bit r);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) applyStimulus(1'b1, d, f && (t == 0), r, acc);
    checkOutput("byte_taken", lastAccept, 1'b1);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    mBytes.delete();
    mValid = 1'b0;
    mPend  = 1'b0;
    mWord  = '0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      checkOutput("rst_in_ready", bus.in_ready, 1'b1);
      checkOutput("rst_out_valid", bus.out_valid, 1'b0);
      checkOutput("rst_out_data", bus.out_data, '0);
      checkOutput("rst_fill", bus.fill_level, '0);
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  initial begin
    bit acc;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    doReset(2);

    $display("[TB] basic packing");
    gotWords.delete();
    offerByte(8'h11, 1'b0, 1'b1);
    offerByte(8'h22, 1'b0, 1'b1);
    offerByte(8'h33, 1'b0, 1'b1);
    offerByte(8'h44, 1'b0, 1'b1);
    idle(2);
    checkOutput("basic_count", gotWords.size(), 1);
    if (gotWords.size() > 0) checkOutput("basic_word", gotWords[0], expect4(8'h11, 8'h22, 8'h33, 8'h44));

    $display("[TB] back-pressure");
    gotWords.delete();
    for (int i = 1; i <= 7; i++) offerByte(byte_t'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b0, acc);
    checkOutput("bp_stall_ready", lastReady, 1'b0);
    checkOutput("bp_stall_fill", lastFill, 3);
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b0, acc);
    checkOutput("bp_still_stalled", lastReady, 1'b0);
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b1, acc);
    checkOutput("bp_accept8", lastAccept, 1'b1);
    idle(2);
    checkOutput("bp_count", gotWords.size(), 2);
    if (gotWords.size() > 1) begin
      checkOutput("bp_word0", gotWords[0], expect4(8'h01, 8'h02, 8'h03, 8'h04));
      checkOutput("bp_word1", gotWords[1], expect4(8'h05, 8'h06, 8'h07, 8'h08));
    end

    $display("[TB] partial flush");
    gotWords.delete();
    offerByte(8'hAB, 1'b0, 1'b1);
    offerByte(8'hCD, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
    idle(3);
    checkOutput("flush_fill", lastFill, 0);
    checkOutput("flush_count", gotWords.size(), 1);
`ifdef PACKER_MSB_FIRST_EN
    if (gotWords.size() > 0) checkOutput("flush_word", gotWords[0], 32'hABCD0000);
`else
    if (gotWords.size() > 0) checkOutput("flush_word", gotWords[0], 32'h0000CDAB);
`endif

    $display("[TB] flush with filling byte");
    gotWords.delete();
    offerByte(8'h11, 1'b0, 1'b1);
    offerByte(8'h22, 1'b0, 1'b1);
    offerByte(8'h33, 1'b0, 1'b1);
    offerByte(8'h44, 1'b1, 1'b1);
    idle(3);
    checkOutput("fillflush_count", gotWords.size(), 1);
    if (gotWords.size() > 0) checkOutput("fillflush_word", gotWords[0], expect4(8'h11, 8'h22, 8'h33, 8'h44));

    $display("[TB] reset mid-word");
    gotWords.delete();
    offerByte(8'h55, 1'b0, 1'b1);
    offerByte(8'h66, 1'b0, 1'b1);
    doReset(2);
    offerByte(8'h11, 1'b0, 1'b1);
    offerByte(8'h22, 1'b0, 1'b1);
    offerByte(8'h33, 1'b0, 1'b1);
    offerByte(8'h44, 1'b0, 1'b1);
    idle(2);
    checkOutput("rstmid_count", gotWords.size(), 1);
    if (gotWords.size() > 0) checkOutput("rstmid_word", gotWords[0], expect4(8'h11, 8'h22, 8'h33, 8'h44));

    $display("[TB] ignored flush");
    gotWords.delete();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
    idle(3);
    checkOutput("ignflush_count", gotWords.size(), 0);
    offerByte(8'hA1, 1'b0, 1'b1);
    offerByte(8'hA2, 1'b0, 1'b1);
    offerByte(8'hA3, 1'b0, 1'b1);
    offerByte(8'hA4, 1'b0, 1'b1);
    idle(2);
    checkOutput("ignflush_next", gotWords.size(), 1);
    if (gotWords.size() > 0) checkOutput("ignflush_word", gotWords[0], expect4(8'hA1, 8'hA2, 8'hA3, 8'hA4));

    $display("[TB] randomized traffic");
    gotWords.delete();
    expWords.delete();
    for (int i = 0; i < 800; i++) begin
      bit v, f, r;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0);
      r = (i % 97 < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
      applyStimulus(v, byte_t'($urandom), f, r, acc);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
    idle(4);
    checkOutput("rand_count", gotWords.size(), expWords.size());
    for (int i = 0; i < gotWords.size() && i < expWords.size(); i++) begin
      checkOutput("rand_word", gotWords[i], expWords[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_word_packer.md
# uart_word_packer

Assembles a stream of UART bytes into wide words for the training datapath. Sits between the UART receiver and the pipelined delay-line (shift-register) stages that carry weights and samples into the MLP. It has a ready/valid handshake on both sides and a one-word output buffer, so a new word can fill while the previous one drains. It also supports flushing a partial, zero-padded word at the end of a record.

## Interface
- `in_width`, default 8: byte width.
- `bytes_per_word`, default 4: bytes per output word, at least 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; the block is in reset while `reset`=0.
- `in_data`  in  `in_width`  byte from the UART receiver.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the packer accepts a byte this cycle.
- `flush`  in  1  one-cycle request to emit the partial word.
- `out_data`  out  `in_width*bytes_per_word`  packed word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  the consumer takes the word this cycle.
- `fill_level`  out  `$clog2(bytes_per_word+1)`  bytes currently held in the accumulator.

## Operation
- **Byte acceptance.** A byte is accepted when `in_valid && in_ready`. It is written to the slot addressed by `fill_level`. All other accumulator slots hold their values.
- **Full word.** When the accepted byte fills the last slot, the full word transfers to the output register. `fill_level` returns to 0 and the accumulator slots clear to 0.
- **Output register.** `out_valid` sets on a transfer and clears on `out_valid && out_ready` unless a new transfer happens in the same cycle. A transfer and a drain in the same cycle are legal: the new word replaces the old one and `out_valid` stays 1.
- **`in_ready`.** `in_ready` is the inverse of `(fill_level==bytes_per_word-1 || flush_pending) && out_valid && !out_ready`. The block stalls input only when a transfer is needed and the output register cannot free up.
- **Flush pending.** A `flush` pulse sets an internal `flush_pending` if `fill_level>0` or a byte is accepted in the same cycle. Otherwise the pulse is ignored.
- **Flush execution.** `flush_pending` executes on the first cycle the output register is free or draining. The partial word transfers with its unfilled slots set to 0, then `fill_level` and `flush_pending` clear.
- **Flush with a byte.** If a byte is accepted in the same cycle a pending flush executes, the byte is included in the flushed word. If that byte fills the word, the flush is satisfied by the full-word transfer.
- **Flush while stalled.** A `flush` arriving while `flush_pending` is already set has no further effect.
- **Reset values.** `in_ready`=1, `out_valid`=0, `out_data`=0, `fill_level`=0, `flush_pending`=0, and the accumulator is 0. Reset asserted mid-word discards the partial word and any held output word.

## Timing
- **Latency.** If the last byte is accepted on edge k, `out_valid` is 1 after edge k, and `out_data` is stable until it is drained.
- **Throughput.** One byte per cycle with no bubbles when `out_ready` is held at 1. A word is produced every `bytes_per_word` cycles.
- **Flush latency.** With the output register free, a `flush` sampled on edge k gives `out_valid` after edge k+1 (one cycle through `flush_pending`).
- **Combinational paths.** `in_ready` depends combinationally on `out_ready`. No other input-to-output paths exist.

## Configuration
- **`PACKER_MSB_FIRST_EN` undefined.** The first byte of a word occupies `out_data[in_width-1:0]` (little-endian).
- **`PACKER_MSB_FIRST_EN` defined.** The first byte occupies the top slot. Zero padding on a flush then sits in the low slots.

## Structure
- **Shared package `packer_pkg`.** Holds the `byte_t` and `word_t` typedefs, the `WORD_W` constant (`in_width*bytes_per_word`), and a `slot_idx_t` typedef sized from `$clog2(bytes_per_word)`.
- **Sub-module `packer_hold_reg`.** Implements the output register together with its valid/ready bookkeeping. The parent contains the accumulator, the slot counter and the flush logic.

## Test plan
All scenarios use `bytes_per_word`=4.
- **Basic packing.** Bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready`=1 → `out_data`=0x44332211 and `out_valid` high for one cycle, one cycle after the fourth byte. With `PACKER_MSB_FIRST_EN` defined → 0x11223344.
- **Back-pressure.** 8 bytes 0x01..0x08 with `out_ready`=0 → the first word is 0x04030201 and is held. `in_ready` drops when `fill_level`=3. Raising `out_ready` drains the first word, after which byte 0x08 is accepted and the next word is 0x08070605.
- **Partial flush.** 0xAB, 0xCD, then a `flush` pulse → `out_data`=0x0000CDAB and `fill_level` is 0 afterward. With `PACKER_MSB_FIRST_EN` defined → 0xABCD0000.
- **Flush with the filling byte.** `flush` in the same cycle as the fourth byte 0x44, after 0x11..0x33 → exactly one word, 0x44332211. No empty word follows.
- **Reset mid-word.** 0x55, 0x66, then `reset`=0 for 2 cycles, then 0x11..0x44 → only 0x44332211 is produced. All outputs are at their reset values while `reset`=0.
- **Ignored flush.** `flush` with `fill_level`=0 and an idle input → no `out_valid`. The next word assembles normally.
